// File: rtl/alu_seq_pkg.sv
// Shared constants for the 6-bit ALU sequencer: opcodes, FSM encodings, IR field slices.
package alu_seq_pkg;

  localparam int WIDTH = 6;
  localparam int NREG  = 4;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_IMM  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int IR_OP_LO = 4;
  localparam int IR_RD_LO = 2;
  localparam int IR_RS_LO = 0;

  function automatic logic [1:0] ir_op(input logic [WIDTH-1:0] ir);
    return ir[IR_OP_LO +: 2];
  endfunction

  function automatic logic [1:0] ir_rd(input logic [WIDTH-1:0] ir);
    return ir[IR_RD_LO +: 2];
  endfunction

  function automatic logic [1:0] ir_rs(input logic [WIDTH-1:0] ir);
    return ir[IR_RS_LO +: 2];
  endfunction

endpackage

// File: rtl/reg_file_4x6.sv
// Architectural register file: two combinational read ports, a debug read port,
// one synchronous write port, synchronous clear to zero.
module reg_file_4x6 import alu_seq_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       raddr_a,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [NREG];

  // Reset has priority so an in-flight write is dropped when rst lands on the write edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer_6_bit.sv
// Multi-cycle execute controller in front of the combinational 6-bit ALU; owns the
// register file, the instruction register and the {CF,SF,ZF} flag register.
//
//  state | meaning
//  IDLE  | ready for an instruction word, latch it into IR on accept
//  EXEC  | drive ALU from IR/register file, write result and flags at closing edge
//  IMM   | ready for the LDI immediate word, write it to R[rd] on accept
//  WB    | retire: one-cycle done pulse
module alu_sequencer_6_bit import alu_seq_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_cf_prev,
  input  logic [5:0] alu_r,
  input  logic       alu_cf,
  input  logic       alu_sf,
  input  logic       alu_zf,
  output logic       done,
  output logic [2:0] flags,
  input  logic [1:0] dbg_sel,
  output logic [5:0] dbg_data
);

  logic [1:0]       state;
  logic [WIDTH-1:0] ir;
  logic [2:0]       flag_q;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic [WIDTH-1:0] wdata;
  logic             in_exec;
  logic             accept;
  logic             we;

  assign in_exec     = (state == ST_EXEC);
  assign instr_ready = !rst && ((state == ST_IDLE) || (state == ST_IMM));
  assign accept      = instr_valid && instr_ready;
  assign we          = in_exec || ((state == ST_IMM) && accept);
  assign wdata       = in_exec ? alu_r : instr;

  assign alu_a       = in_exec ? rdata_a : '0;
  assign alu_b       = in_exec ? rdata_b : '0;
  assign alu_op      = in_exec ? ir_op(ir) : 2'b00;
  assign alu_cf_prev = in_exec && flag_q[2];
  assign done        = (state == ST_WB);
  assign flags       = flag_q;

  reg_file_4x6 u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (ir_rd(ir)),
    .wdata    (wdata),
    .raddr_a  (ir_rd(ir)),
    .raddr_b  (ir_rs(ir)),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ir     <= '0;
      flag_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ir    <= instr;
            state <= (ir_op(instr) == OP_LDI) ? ST_IMM : ST_EXEC;
          end
        end
        ST_EXEC: begin
          flag_q <= {alu_cf, alu_sf, alu_zf};
          state  <= ST_WB;
        end
        ST_IMM: begin
          if (accept) state <= ST_WB;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer_6_bit.sv
// Directed bench for alu_sequencer_6_bit with a behavioural 6-bit ALU attached.
module tb_alu_sequencer_6_bit;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [5:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_cf_prev, alu_cf, alu_sf, alu_zf;
  logic       done;
  logic [2:0] flags;
  logic [1:0] dbg_sel = '0;
  logic [5:0] dbg_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer_6_bit dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_cf_prev(alu_cf_prev), .alu_r(alu_r), .alu_cf(alu_cf), .alu_sf(alu_sf),
    .alu_zf(alu_zf), .done(done), .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Golden ALU: OR, ADD (no carry-in), ROL through carry.
  always_comb begin
    logic [6:0] sum;
    sum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_r  = '0;
    alu_cf = 1'b0;
    case (alu_op)
      OP_OR:   alu_r = alu_a | alu_b;
      OP_ADD:  begin alu_r = sum[5:0]; alu_cf = sum[6]; end
      OP_ROL:  begin alu_r = {alu_a[4:0], alu_cf_prev}; alu_cf = alu_a[5]; end
      default: alu_r = '0;
    endcase
    alu_sf = alu_r[5];
    alu_zf = (alu_r == 6'd0);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {7'b0, obs}, {7'b0, exp});
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [5:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, {2'b0, dbg_data}, {2'b0, exp});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [5:0] w);
    int t = 0;
    instr = w;
    instr_valid = 1'b1;
    #1;
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk1("accept_wait", instr_ready, 1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = '0;
  endtask

  task automatic ldi(input string tag, input logic [1:0] rd, input logic [5:0] imm);
    send({OP_LDI, rd, 2'b00});
    #1;
    chk1({tag, "_imm_ready"}, instr_ready, 1'b1);
    chk({tag, "_imm_alu_a"}, {2'b0, alu_a}, 8'h00);
    chk({tag, "_imm_alu_op"}, {6'b0, alu_op}, 8'h00);
    send(imm);
    #1;
    chk1({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    chk_reg({tag, "_reg"}, rd, imm);
  endtask

  task automatic alu_instr(input string tag, input logic [5:0] w, input logic [5:0] ea,
                           input logic [5:0] eb, input logic ecf);
    send(w);
    #1;
    chk({tag, "_alu_a"}, {2'b0, alu_a}, {2'b0, ea});
    chk({tag, "_alu_b"}, {2'b0, alu_b}, {2'b0, eb});
    chk({tag, "_alu_op"}, {6'b0, alu_op}, {6'b0, w[5:4]});
    chk1({tag, "_cf_prev"}, alu_cf_prev, ecf);
    chk1({tag, "_exec_ready"}, instr_ready, 1'b0);
    chk1({tag, "_exec_done"}, done, 1'b0);
    @(negedge clk);
    #1;
    chk1({tag, "_wb_done"}, done, 1'b1);
    @(negedge clk);
    #1;
    chk1({tag, "_idle_done"}, done, 1'b0);
    chk1({tag, "_idle_ready"}, instr_ready, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk1("rst_done", done, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rst_ready", instr_ready, 1'b1);
    chk("rst_flags", {5'b0, flags}, 8'h00);
    chk("rst_alu_a", {2'b0, alu_a}, 8'h00);
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", i[1:0], 6'h00);

    ldi("ldi_r0", 2'd0, 6'h3F);
    ldi("ldi_r1", 2'd1, 6'h01);
    alu_instr("add_r0_r1", {OP_ADD, 2'd0, 2'd1}, 6'h3F, 6'h01, 1'b0);
    chk_reg("add_r0", 2'd0, 6'h00);
    chk("add_flags", {5'b0, flags}, 8'h05);
    chk_reg("add_r1_kept", 2'd1, 6'h01);

    ldi("ldi_r2", 2'd2, 6'h2A);
    ldi("ldi_r3", 2'd3, 6'h15);
    alu_instr("or_r2_r3", {OP_OR, 2'd2, 2'd3}, 6'h2A, 6'h15, 1'b1);
    chk_reg("or_r2", 2'd2, 6'h3F);
    chk("or_flags", {5'b0, flags}, 8'h02);

    alu_instr("add_r3_r2", {OP_ADD, 2'd3, 2'd2}, 6'h15, 6'h3F, 1'b0);
    chk_reg("add_r3", 2'd3, 6'h14);
    chk("add_carry_flags", {5'b0, flags}, 8'h04);
    alu_instr("rol_r3_r3", {OP_ROL, 2'd3, 2'd3}, 6'h14, 6'h14, 1'b1);
    chk_reg("rol_r3", 2'd3, 6'h29);
    chk("rol_flags", {5'b0, flags}, 8'h02);

    // Valid held high across two ADD R1,R1: accept only in IDLE, one done each.
    instr = {OP_ADD, 2'd1, 2'd1};
    instr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk1("hold_ready", instr_ready, (k % 3) == 0);
      chk1("hold_done", done, (k % 3) == 2);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk_reg("hold_r1", 2'd1, 6'h04);
    chk("hold_flags", {5'b0, flags}, 8'h00);

    // Valid held high with an LDI word: the same word becomes the immediate.
    instr = {OP_LDI, 2'd1, 2'd0};
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("hold_ldi_ready", instr_ready, k != 2);
      chk1("hold_ldi_done", done, k == 2);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk_reg("hold_ldi_r1", 2'd1, 6'h34);

    // Reset while in EXEC.
    send({OP_ADD, 2'd2, 2'd3});
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk1("rst_exec_done", done, 1'b0);
    chk("rst_exec_flags", {5'b0, flags}, 8'h00);
    for (int i = 0; i < 4; i++) chk_reg("rst_exec_reg", i[1:0], 6'h00);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk1("rst_exec_after_done", done, 1'b0);
    chk1("rst_exec_after_ready", instr_ready, 1'b1);

    // Reset while in IMM with the immediate pending.
    ldi("ldi_r0_b", 2'd0, 6'h15);
    send({OP_LDI, 2'd1, 2'd0});
    instr = 6'h2A;
    instr_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk1("rst_imm_done", done, 1'b0);
    chk_reg("rst_imm_r1", 2'd1, 6'h00);
    chk_reg("rst_imm_r0", 2'd0, 6'h00);
    rst = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk1("rst_imm_after_done", done, 1'b0);
    chk1("rst_imm_after_ready", instr_ready, 1'b1);
    chk_reg("rst_imm_after_r1", 2'd1, 6'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
